// File: rtl/free_list_pkg.sv
// rtl/free_list_pkg.sv - shared rename constants and types for the free list
package free_list_pkg;

  localparam int N         = 2;
  localparam int PHYS_REGS = 64;
  localparam int ARCH_REGS = 32;
  localparam int FL_DEPTH  = PHYS_REGS - ARCH_REGS;

  localparam int PREG_W = $clog2(PHYS_REGS);
  localparam int PTR_W  = $clog2(FL_DEPTH) + 1;
  localparam int IDX_W  = PTR_W - 1;
  localparam int CNT_W  = $clog2(FL_DEPTH + 1);
  localparam int NUM_W  = $clog2(N + 1);
  localparam int LANE_W = (N > 1) ? $clog2(N) : 1;

  typedef logic [PREG_W-1:0] preg_idx_t;
  typedef logic [PTR_W-1:0]  fl_ptr_t;
  typedef logic [IDX_W-1:0]  fl_idx_t;
  typedef logic [CNT_W-1:0]  fl_cnt_t;
  typedef logic [NUM_W-1:0]  fl_num_t;

endpackage

// File: rtl/free_list_if.sv
// rtl/free_list_if.sv - allocate/free/recovery bus between rename logic and the free list
//   master (rename): drives rd_num, wr_en, wr_reg, restore_en, restore_head
//   slave (free_list): drives rd_reg, rd_valid, free_cnt, head_out
interface free_list_if;
  import free_list_pkg::*;

  fl_num_t           rd_num;
  preg_idx_t [N-1:0] rd_reg;
  logic [N-1:0]      rd_valid;
  logic [N-1:0]      wr_en;
  preg_idx_t [N-1:0] wr_reg;
  fl_cnt_t           free_cnt;
  fl_ptr_t           head_out;
  logic              restore_en;
  fl_ptr_t           restore_head;

  modport master (
    output rd_num, wr_en, wr_reg, restore_en, restore_head,
    input  rd_reg, rd_valid, free_cnt, head_out
  );

  modport slave (
    input  rd_num, wr_en, wr_reg, restore_en, restore_head,
    output rd_reg, rd_valid, free_cnt, head_out
  );

endinterface

// File: rtl/free_list_mem.sv
// rtl/free_list_mem.sv - N-write/N-read register array holding free preg indices
//   clock, reset : reset seeds entry k with ARCH_REGS+k
//   wr_en/wr_addr/wr_data : N write ports, applied at posedge
//   rd_addr/rd_data       : N combinational read ports
module free_list_mem
  import free_list_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [N-1:0]      wr_en,
  input  fl_idx_t [N-1:0]   wr_addr,
  input  preg_idx_t [N-1:0] wr_data,
  input  fl_idx_t [N-1:0]   rd_addr,
  output preg_idx_t [N-1:0] rd_data
);

  preg_idx_t mem [FL_DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < FL_DEPTH; k++) begin
        mem[k] <= preg_idx_t'(ARCH_REGS + k);
      end
    end else begin
      // Packed lanes always target distinct addresses, so port order is irrelevant.
      for (int p = 0; p < N; p++) begin
        if (wr_en[p]) mem[wr_addr[p]] <= wr_data[p];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      rd_data[i] = mem[rd_addr[i]];
    end
  end

endmodule

// File: rtl/free_list.sv
// rtl/free_list.sv - circular FIFO of free physical registers for R10K rename
//   clock, reset : synchronous active-high reset
//   fl (slave)   : rd_num/rd_reg/rd_valid allocate at head, wr_en/wr_reg free at tail,
//                  free_cnt stored count, head_out checkpoint, restore_en/restore_head recovery
//   FREE_LIST_BYPASS_EN : frees of this cycle are allocatable in the same cycle
module free_list
  import free_list_pkg::*;
(
  input logic       clock,
  input logic       reset,
  free_list_if.slave fl
);

  fl_ptr_t           head;
  fl_ptr_t           tail;
  fl_cnt_t           stored_cnt;
  fl_num_t           wr_pop;
  logic [CNT_W:0]    avail;
  fl_idx_t [N-1:0]   wr_addr;
  fl_idx_t [N-1:0]   rd_addr;
  preg_idx_t [N-1:0] mem_rd;

  // Wrap bit makes tail-head span 0..DEPTH without ambiguity.
  assign stored_cnt  = fl_cnt_t'(tail - head);
  assign fl.free_cnt = stored_cnt;
  assign fl.head_out = head;

  // Each enabled lane writes at tail plus the number of enabled lanes below it.
  always_comb begin
    int k;
    k = 0;
    for (int j = 0; j < N; j++) begin
      wr_addr[j] = fl_idx_t'(tail + PTR_W'(k));
      if (fl.wr_en[j]) k++;
    end
    wr_pop = NUM_W'(k);
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      rd_addr[i] = fl_idx_t'(head + PTR_W'(i));
    end
  end

  free_list_mem u_mem (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (fl.wr_en),
    .wr_addr (wr_addr),
    .wr_data (fl.wr_reg),
    .rd_addr (rd_addr),
    .rd_data (mem_rd)
  );

`ifdef FREE_LIST_BYPASS_EN
  preg_idx_t [N-1:0] byp_reg;

  always_comb begin
    int k;
    k = 0;
    byp_reg = '0;
    for (int j = 0; j < N; j++) begin
      if (fl.wr_en[j]) begin
        byp_reg[LANE_W'(k)] = fl.wr_reg[j];
        k++;
      end
    end
  end

  assign avail = {1'b0, stored_cnt} + (CNT_W+1)'(wr_pop);
`else
  assign avail = {1'b0, stored_cnt};
`endif

  always_comb begin
    logic lane_ok;
    for (int i = 0; i < N; i++) begin
      lane_ok        = ((CNT_W+1)'(i) < avail);
      fl.rd_valid[i] = lane_ok;
      fl.rd_reg[i]   = lane_ok ? mem_rd[i] : '0;
`ifdef FREE_LIST_BYPASS_EN
      // Lanes past the stored entries take the freshly freed pregs in packed order.
      if (lane_ok && ((CNT_W+1)'(i) >= {1'b0, stored_cnt})) begin
        fl.rd_reg[i] = byp_reg[LANE_W'(i - int'(stored_cnt))];
      end
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head <= '0;
      tail <= PTR_W'(FL_DEPTH);
    end else begin
      // Retirement is older than any mispredicted branch, so frees land even during recovery.
      tail <= tail + PTR_W'(wr_pop);
      if (fl.restore_en) begin
        head <= fl.restore_head;
      end else if ((CNT_W+1)'(fl.rd_num) <= avail) begin
        head <= head + PTR_W'(fl.rd_num);
      end
    end
  end

endmodule
